// File: rtl/alu_op_sequencer.sv
// Issue-side controller for the 5-register sfixed ALU: accepts one decoded instruction,
// strobes the ALU operand registers, waits the result latency and emits a register-file write-back.
module alu_op_sequencer #(
  parameter int BUS_WIDTH  = 8,
  parameter int RADDR_W    = 3,
  parameter int RESULT_LAT = 1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [1:0]           instr_op,
  input  logic [RADDR_W-1:0]   instr_rd,
  input  logic [RADDR_W-1:0]   instr_ra,
  input  logic [RADDR_W-1:0]   instr_rb,
  input  logic [BUS_WIDTH-1:0] instr_imm,
  output logic [RADDR_W-1:0]   rf_addr_a,
  output logic [RADDR_W-1:0]   rf_addr_b,
  output logic [BUS_WIDTH-1:0] imm,
  output logic                 f_add,
  output logic                 f_load,
  output logic [4:0]           reg_en,
  input  logic [BUS_WIDTH-1:0] result,
  output logic                 wb_en,
  output logic [RADDR_W-1:0]   wb_addr,
  output logic [BUS_WIDTH-1:0] wb_data,
  output logic [15:0]          retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDSW = 2'b01;
  localparam logic [1:0] OP_MOV  = 2'b10;
  localparam logic [1:0] OP_MACI = 2'b11;

  localparam int CNT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESULT_LAT - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [RADDR_W-1:0]   r_rd;
  logic                 r_ready;
  logic [RADDR_W-1:0]   r_rf_addr_a;
  logic [RADDR_W-1:0]   r_rf_addr_b;
  logic [BUS_WIDTH-1:0] r_imm;
  logic                 r_f_add;
  logic                 r_f_load;
  logic [4:0]           r_reg_en;
  logic                 r_wb_en;
  logic [RADDR_W-1:0]   r_wb_addr;
  logic [BUS_WIDTH-1:0] r_wb_data;
  logic [15:0]          r_retired;

  logic [4:0] w_reg_en;
  logic       w_f_add;
  logic       w_f_load;
  logic       w_accept;
  logic       w_wb_ok;

  assign w_accept = instr_valid && r_ready;
  assign w_wb_ok  = (ZERO_REG && (r_rd == {RADDR_W{1'b0}})) ? 1'b0 : 1'b1;

  // Opcode decode into ALU control; strobe pattern is {E,D,C,B,A}
  always_comb begin
    w_reg_en = 5'b00000;
    w_f_add  = 1'b0;
    w_f_load = 1'b0;
    case (instr_op)
      OP_LDSW: w_reg_en = 5'b11010;
      OP_MOV: begin
        w_reg_en = 5'b11010;
        w_f_load = 1'b1;
      end
      OP_MACI: begin
        w_reg_en = 5'b11111;
        w_f_add  = 1'b1;
      end
      default: w_reg_en = 5'b00000;
    endcase
  end

  // Sequencer FSM; ISSUE outputs are loaded on the accept edge so they are visible during ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_rd        <= {RADDR_W{1'b0}};
      r_ready     <= 1'b1;
      r_rf_addr_a <= {RADDR_W{1'b0}};
      r_rf_addr_b <= {RADDR_W{1'b0}};
      r_imm       <= {BUS_WIDTH{1'b0}};
      r_f_add     <= 1'b0;
      r_f_load    <= 1'b0;
      r_reg_en    <= 5'b00000;
      r_wb_en     <= 1'b0;
      r_wb_addr   <= {RADDR_W{1'b0}};
      r_wb_data   <= {BUS_WIDTH{1'b0}};
      r_retired   <= 16'd0;
    end else begin
      r_reg_en <= 5'b00000;
      r_wb_en  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (instr_op == OP_NOP) begin
              r_retired <= r_retired + 16'd1;
            end else begin
              r_state     <= S_ISSUE;
              r_ready     <= 1'b0;
              r_rd        <= instr_rd;
              r_rf_addr_a <= instr_ra;
              r_rf_addr_b <= instr_rb;
              r_imm       <= instr_imm;
              r_f_add     <= w_f_add;
              r_f_load    <= w_f_load;
              r_reg_en    <= w_reg_en;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= CNT_INIT;
        end
        S_WAIT: begin
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_state   <= S_WB;
            r_wb_data <= result;
            r_wb_addr <= r_rd;
            r_wb_en   <= w_wb_ok;
            r_retired <= r_retired + 16'd1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign rf_addr_a   = r_rf_addr_a;
  assign rf_addr_b   = r_rf_addr_b;
  assign imm         = r_imm;
  assign f_add       = r_f_add;
  assign f_load      = r_f_load;
  assign reg_en      = r_reg_en;
  assign wb_en       = r_wb_en;
  assign wb_addr     = r_wb_addr;
  assign wb_data     = r_wb_data;
  assign retired     = r_retired;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: register-file and ALU stubs around the DUT, a sequential
// instruction-level reference model, plus a RESULT_LAT=3 instance for latency checks.
module tb_alu_op_sequencer;

  localparam int LAT = 1;
  localparam logic [1:0] NOP = 2'b00, LDSW = 2'b01, MOV = 2'b10, MACI = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [1:0] instr_op = 2'b00;
  logic [2:0] instr_rd = 3'd0, instr_ra = 3'd0, instr_rb = 3'd0;
  logic [7:0] instr_imm = 8'd0;
  logic [2:0] rf_addr_a, rf_addr_b;
  logic [7:0] imm;
  logic       f_add, f_load;
  logic [4:0] reg_en;
  logic [7:0] result;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [15:0] retired;
  logic [7:0] sw = 8'd0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.BUS_WIDTH(8), .RADDR_W(3), .RESULT_LAT(LAT), .ZERO_REG(1'b1)) u_dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_imm(instr_imm), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .imm(imm),
    .f_add(f_add), .f_load(f_load), .reg_en(reg_en), .result(result), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .retired(retired)
  );

  // Register file with a seeding port
  logic [7:0] rf [8];
  logic       seed_we = 1'b0;
  logic [2:0] seed_addr = 3'd0;
  logic [7:0] seed_data = 8'd0;
  always_ff @(posedge clk) begin
    if (seed_we) rf[seed_addr] <= seed_data;
    else if (wb_en) rf[wb_addr] <= wb_data;
  end

  // ALU stub: operand registers A..E, result = A*C + B*D + E in add mode, else E
  logic [7:0] data_a, data_b;
  logic [7:0] alu_a = 8'd0, alu_b = 8'd0, alu_c = 8'd0, alu_d = 8'd0, alu_e = 8'd0;
  logic       alu_mode = 1'b0;
  assign data_a = rf[rf_addr_a];
  assign data_b = rf[rf_addr_b];
  always_ff @(posedge clk) begin
    if (reg_en[0]) alu_a <= data_a;
    if (reg_en[1]) alu_b <= f_add ? data_b : 8'h00;
    if (reg_en[2]) alu_c <= imm;
    if (reg_en[3]) alu_d <= f_add ? imm : 8'h00;
    if (reg_en[4]) alu_e <= f_add ? imm : (f_load ? data_a : sw);
    if (reg_en != 5'b00000) alu_mode <= f_add;
  end
  assign result = alu_mode ? (alu_a * alu_c + alu_b * alu_d + alu_e) : alu_e;

  // RESULT_LAT=3 instance, ALU result driven directly by the bench
  logic       l3_valid = 1'b0;
  logic       l3_ready;
  logic [7:0] l3_res = 8'd0;
  logic [2:0] l3_addr_a, l3_addr_b, l3_wb_addr;
  logic [7:0] l3_imm, l3_wb_data;
  logic       l3_f_add, l3_f_load, l3_wb_en;
  logic [4:0] l3_reg_en;
  logic [15:0] l3_retired;

  alu_op_sequencer #(.BUS_WIDTH(8), .RADDR_W(3), .RESULT_LAT(3), .ZERO_REG(1'b1)) u_dut3 (
    .clk(clk), .rst(rst), .instr_valid(l3_valid), .instr_ready(l3_ready),
    .instr_op(LDSW), .instr_rd(3'd3), .instr_ra(3'd1), .instr_rb(3'd2),
    .instr_imm(8'h11), .rf_addr_a(l3_addr_a), .rf_addr_b(l3_addr_b), .imm(l3_imm),
    .f_add(l3_f_add), .f_load(l3_f_load), .reg_en(l3_reg_en), .result(l3_res),
    .wb_en(l3_wb_en), .wb_addr(l3_wb_addr), .wb_data(l3_wb_data), .retired(l3_retired)
  );

  // Reference model state
  logic [7:0]  m_rf [8];
  logic [15:0] m_ret = 16'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [2:0] ra,
                                            input logic [2:0] rb, input logic [7:0] iv,
                                            input logic [7:0] swv);
    int t;
    case (op)
      LDSW:    t = int'(swv);
      MOV:     t = int'(m_rf[ra]);
      MACI:    t = int'(iv) * int'(m_rf[ra]) + int'(iv) * int'(m_rf[rb]) + int'(iv);
      default: t = 0;
    endcase
    return t[7:0];
  endfunction

  // Runs one instruction from idle and checks every cycle until the DUT is idle again
  task automatic run_instr(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] ra,
                           input logic [2:0] rb, input logic [7:0] iv, input logic [7:0] swv);
    logic [7:0] e_res;
    logic [4:0] e_en;
    logic       e_wb;
    e_res = ref_result(op, ra, rb, iv, swv);
    chk("ready_pre", 32'(instr_ready), 32'd1);
    sw = swv; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = iv;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    if (op == NOP) begin
      m_ret = m_ret + 16'd1;
      chk("nop_reg_en", 32'(reg_en), 32'd0);
      chk("nop_wb_en", 32'(wb_en), 32'd0);
      chk("nop_ready", 32'(instr_ready), 32'd1);
      chk("nop_retired", 32'(retired), 32'(m_ret));
    end else begin
      e_en = (op == MACI) ? 5'b11111 : 5'b11010;
      chk("iss_reg_en", 32'(reg_en), 32'(e_en));
      chk("iss_f_add", 32'(f_add), 32'(op == MACI));
      chk("iss_f_load", 32'(f_load), 32'(op == MOV));
      chk("iss_addr_a", 32'(rf_addr_a), 32'(ra));
      chk("iss_addr_b", 32'(rf_addr_b), 32'(rb));
      chk("iss_imm", 32'(imm), 32'(iv));
      chk("iss_wb_en", 32'(wb_en), 32'd0);
      chk("iss_ready", 32'(instr_ready), 32'd0);
      for (int i = 0; i < LAT; i++) begin
        @(negedge clk);
        chk("wait_reg_en", 32'(reg_en), 32'd0);
        chk("wait_wb_en", 32'(wb_en), 32'd0);
      end
      @(negedge clk);
      e_wb = (rd != 3'd0);
      m_ret = m_ret + 16'd1;
      chk("wb_en", 32'(wb_en), 32'(e_wb));
      chk("wb_addr", 32'(wb_addr), 32'(rd));
      chk("wb_data", 32'(wb_data), 32'(e_res));
      chk("wb_reg_en", 32'(reg_en), 32'd0);
      chk("wb_retired", 32'(retired), 32'(m_ret));
      if (e_wb) m_rf[rd] = e_res;
      @(negedge clk);
      chk("post_ready", 32'(instr_ready), 32'd1);
      chk("post_wb_en", 32'(wb_en), 32'd0);
    end
  endtask

  logic [1:0] b_op [4];
  logic [2:0] b_rd [4], b_ra [4], b_rb [4];
  logic [7:0] b_imm [4];

  initial begin
    int idx, cyc;
    int acc_cyc [4];
    logic will_acc;

    // Reset while seeding the register file (R1=3, R4=2)
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seed_we = 1'b1; seed_addr = 3'(i);
      seed_data = (i == 1) ? 8'd3 : (i == 4) ? 8'd2 : 8'($urandom);
      m_rf[i] = seed_data;
    end
    @(negedge clk);
    seed_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_reg_en", 32'(reg_en), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_f_add", 32'(f_add), 32'd0);
    chk("rst_f_load", 32'(f_load), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);
    chk("rst_addr_a", 32'(rf_addr_a), 32'd0);
    chk("rst_addr_b", 32'(rf_addr_b), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);

    // Directed cases
    run_instr(LDSW, 3'd2, 3'd0, 3'd0, 8'h00, 8'h05);
    run_instr(MACI, 3'd5, 3'd1, 3'd4, 8'h02, 8'h00);
    chk("maci_rf5", 32'(rf[5]), 32'h0C);
    run_instr(MOV, 3'd0, 3'd3, 3'd0, 8'h00, 8'h00);
    run_instr(NOP, 3'd1, 3'd1, 3'd1, 8'h00, 8'h00);

    // Back-to-back with valid held high
    b_op  = '{MOV, MACI, LDSW, MOV};
    b_rd  = '{3'd6, 3'd7, 3'd5, 3'd0};
    b_ra  = '{3'd1, 3'd6, 3'd2, 3'd7};
    b_rb  = '{3'd0, 3'd4, 3'd3, 3'd1};
    b_imm = '{8'h00, 8'h03, 8'h00, 8'h00};
    sw = 8'h3C;
    idx = 0; cyc = 0;
    instr_op = b_op[0]; instr_rd = b_rd[0]; instr_ra = b_ra[0]; instr_rb = b_rb[0];
    instr_imm = b_imm[0]; instr_valid = 1'b1;
    while (idx < 4 && cyc < 40) begin
      will_acc = instr_ready;
      @(negedge clk);
      cyc++;
      if (will_acc) begin
        acc_cyc[idx] = cyc;
        if (b_rd[idx] != 3'd0) m_rf[b_rd[idx]] = ref_result(b_op[idx], b_ra[idx], b_rb[idx], b_imm[idx], sw);
        m_ret = m_ret + 16'd1;
        idx++;
        if (idx < 4) begin
          instr_op = b_op[idx]; instr_rd = b_rd[idx]; instr_ra = b_ra[idx];
          instr_rb = b_rb[idx]; instr_imm = b_imm[idx];
        end else begin
          instr_valid = 1'b0;
        end
      end
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", 32'(idx), 32'd4);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(LAT + 3));
    repeat (LAT + 3) @(negedge clk);
    chk("b2b_retired", 32'(retired), 32'(m_ret));
    chk("b2b_ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 8; i++) chk("b2b_rf", 32'(rf[i]), 32'(m_rf[i]));

    // Reset during WAIT of a MACI abandons it
    instr_op = MACI; instr_rd = 3'd3; instr_ra = 3'd1; instr_rb = 3'd4; instr_imm = 8'h07;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ret = 16'd0;
    for (int i = 0; i < 6; i++) begin
      chk("rstw_wb_en", 32'(wb_en), 32'd0);
      chk("rstw_reg_en", 32'(reg_en), 32'd0);
      @(negedge clk);
    end
    chk("rstw_ready", 32'(instr_ready), 32'd1);
    chk("rstw_retired", 32'(retired), 32'd0);
    chk("rstw_rf3", 32'(rf[3]), 32'(m_rf[3]));
    run_instr(MOV, 3'd3, 3'd5, 3'd0, 8'h00, 8'h00);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      run_instr(2'($urandom_range(3, 0)), 3'($urandom), 3'($urandom), 3'($urandom),
                8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 8; i++) chk("rand_rf", 32'(rf[i]), 32'(m_rf[i]));

    // RESULT_LAT=3 instance: write-back four cycles after ISSUE
    l3_res = 8'hA5;
    chk("l3_ready_pre", 32'(l3_ready), 32'd1);
    l3_valid = 1'b1;
    @(negedge clk);
    l3_valid = 1'b0;
    chk("l3_reg_en", 32'(l3_reg_en), 32'h1A);
    chk("l3_f_add", 32'(l3_f_add), 32'd0);
    chk("l3_f_load", 32'(l3_f_load), 32'd0);
    chk("l3_addr_a", 32'(l3_addr_a), 32'd1);
    chk("l3_addr_b", 32'(l3_addr_b), 32'd2);
    chk("l3_imm", 32'(l3_imm), 32'h11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l3_wait_wb_en", 32'(l3_wb_en), 32'd0);
      chk("l3_wait_reg_en", 32'(l3_reg_en), 32'd0);
    end
    @(negedge clk);
    chk("l3_wb_en", 32'(l3_wb_en), 32'd1);
    chk("l3_wb_addr", 32'(l3_wb_addr), 32'd3);
    chk("l3_wb_data", 32'(l3_wb_data), 32'hA5);
    chk("l3_retired", 32'(l3_retired), 32'd1);
    @(negedge clk);
    chk("l3_post_ready", 32'(l3_ready), 32'd1);
    chk("l3_post_wb_en", 32'(l3_wb_en), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
